// File: rtl/rst_ctrl_pkg.sv
// Shared definitions for the reset / pushbutton controller: FSM encoding,
// default parameter values and a counter-width helper.
package rst_ctrl_pkg;

  typedef enum logic [1:0] {
    S_POR   = 2'd0,
    S_RUN   = 2'd1,
    S_PBRST = 2'd2
  } rst_state_t;

  localparam int NUM_PB_DEF     = 4;
  localparam int POR_CYCLES_DEF = 14;
  localparam int DEB_CYCLES_DEF = 500000;
  localparam int DIV_DEF        = 2;
  localparam int CNT_WIDTH_DEF  = 26;
  localparam int RST_PB_DEF     = 0;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_bits(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rst_ctrl_gen_if.sv
// Bundle of pushbutton inputs and reset/timing outputs of rst_ctrl_gen.
// master = the controller, slave = the board/consumer side.
interface rst_ctrl_gen_if #(
  parameter int NUM_PB    = 4,
  parameter int CNT_WIDTH = 26
);
  logic [NUM_PB-1:0]    PB;
  logic                 sys_rst;
  logic [NUM_PB-1:0]    pb_level;
  logic [NUM_PB-1:0]    pb_press;
  logic [NUM_PB-1:0]    pb_release;
  logic                 ce_div;
  logic [CNT_WIDTH-1:0] free_cnt;

  modport master (
    input  PB,
    output sys_rst, pb_level, pb_press, pb_release, ce_div, free_cnt
  );

  modport slave (
    output PB,
    input  sys_rst, pb_level, pb_press, pb_release, ce_div, free_cnt
  );
endinterface

// File: rtl/pb_debounce.sv
// One pushbutton channel: 2-flop synchroniser, stability counter,
// debounced level (1 = pressed) and one-cycle press/release pulses.
module pb_debounce
  import rst_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic SYS_CLK,
  input  logic RSTn,
  input  logic pb_in,
  output logic pb_level,
  output logic pb_press,
  output logic pb_release
);

  localparam int            DW       = cnt_bits(DEB_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [1:0]    sync_reg;
  logic [DW-1:0] deb_cnt_reg;
  logic          level_reg;
  logic          press_reg;
  logic          release_reg;
  logic          differ;

  // Raw button is active-low; compare the pressed sense with the level.
  assign differ = (~sync_reg[1]) ^ level_reg;

  // Two-flop synchroniser, idles at 1 (button released).
  always_ff @(posedge SYS_CLK or negedge RSTn) begin
    if (!RSTn) sync_reg <= 2'b11;
    else       sync_reg <= {sync_reg[0], pb_in};
  end

  // Count disagreeing cycles; flip the level after DEB_CYCLES of them.
  always_ff @(posedge SYS_CLK or negedge RSTn) begin
    if (!RSTn) begin
      deb_cnt_reg <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      if (!differ) begin
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg == DEB_LAST) begin
        deb_cnt_reg <= '0;
        level_reg   <= ~level_reg;
        press_reg   <= ~level_reg;
        release_reg <= level_reg;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + DW'(1);
      end
    end
  end

  assign pb_level   = level_reg;
  assign pb_press   = press_reg;
  assign pb_release = release_reg;

endmodule

// File: rtl/rst_ctrl_gen.sv
// Reset controller: power-on hold, pushbutton-forced reset, debounced
// buttons, a clock-enable divider and a free-running counter.
module rst_ctrl_gen
  import rst_ctrl_pkg::*;
#(
  parameter int NUM_PB     = NUM_PB_DEF,
  parameter int POR_CYCLES = POR_CYCLES_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int DIV        = DIV_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int RST_PB     = RST_PB_DEF
) (
  input logic            SYS_CLK,
  input logic            RSTn,
  rst_ctrl_gen_if.master bus
);

  localparam int            HW        = cnt_bits(POR_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(POR_CYCLES - 1);
  localparam int            VW        = cnt_bits(DIV - 1);
  localparam logic [VW-1:0] DIV_LAST  = VW'(DIV - 1);

  logic [NUM_PB-1:0]    pb_level_w;
  logic [NUM_PB-1:0]    pb_press_w;
  logic [NUM_PB-1:0]    pb_release_w;
  rst_state_t           state_reg, state_next;
  logic [HW-1:0]        hold_reg, hold_next;
  logic                 sys_rst_reg;
  logic [VW-1:0]        div_cnt_reg;
  logic [CNT_WIDTH-1:0] free_cnt_reg;
  logic                 rst_btn;

  for (genvar gi = 0; gi < NUM_PB; gi++) begin : g_pb
    pb_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .SYS_CLK    (SYS_CLK),
      .RSTn       (RSTn),
      .pb_in      (bus.PB[gi]),
      .pb_level   (pb_level_w[gi]),
      .pb_press   (pb_press_w[gi]),
      .pb_release (pb_release_w[gi])
    );
  end

  assign rst_btn = pb_level_w[RST_PB];

  // Next state: POR hold countdown, button-forced reset, back through POR.
  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    case (state_reg)
      S_POR: begin
        if (hold_reg == HOLD_LAST) begin
          state_next = S_RUN;
          hold_next  = '0;
        end else begin
          hold_next = hold_reg + HW'(1);
        end
      end
      S_RUN: begin
        if (rst_btn) state_next = S_PBRST;
      end
      S_PBRST: begin
        if (!rst_btn) begin
          state_next = S_POR;
          hold_next  = '0;
        end
      end
      default: begin
        state_next = S_POR;
        hold_next  = '0;
      end
    endcase
  end

  // State, hold counter and registered system reset.
  always_ff @(posedge SYS_CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_reg   <= S_POR;
      hold_reg    <= '0;
      sys_rst_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      hold_reg    <= hold_next;
      sys_rst_reg <= (state_next != S_RUN);
    end
  end

  // Modulo-DIV counter for the clock enable; ignores sys_rst.
  always_ff @(posedge SYS_CLK or negedge RSTn) begin
    if (!RSTn)                      div_cnt_reg <= '0;
    else if (div_cnt_reg == DIV_LAST) div_cnt_reg <= '0;
    else                            div_cnt_reg <= div_cnt_reg + VW'(1);
  end

  // Free-running counter, held at zero while the system is in reset.
  always_ff @(posedge SYS_CLK or negedge RSTn) begin
    if (!RSTn)            free_cnt_reg <= '0;
    else if (sys_rst_reg) free_cnt_reg <= '0;
    else                  free_cnt_reg <= free_cnt_reg + CNT_WIDTH'(1);
  end

  assign bus.sys_rst    = sys_rst_reg;
  assign bus.pb_level   = pb_level_w;
  assign bus.pb_press   = pb_press_w;
  assign bus.pb_release = pb_release_w;
  assign bus.ce_div     = (div_cnt_reg == DIV_LAST);
  assign bus.free_cnt   = free_cnt_reg;

endmodule

// File: tb/tb_rst_ctrl_gen.sv
// Directed bench for rst_ctrl_gen with small parameters.
module tb_rst_ctrl_gen;

  logic SYS_CLK = 1'b0;
  logic RSTn;
  int   checks = 0;
  int   errors = 0;

  rst_ctrl_gen_if #(.NUM_PB(2), .CNT_WIDTH(4)) bus ();

  rst_ctrl_gen #(
    .NUM_PB     (2),
    .POR_CYCLES (15),
    .DEB_CYCLES (4),
    .DIV        (2),
    .CNT_WIDTH  (4),
    .RST_PB     (0)
  ) dut (
    .SYS_CLK (SYS_CLK),
    .RSTn    (RSTn),
    .bus     (bus.master)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end else begin
      $display("ok   %s value=%0d", tag, obs);
    end
  endtask

  // One rising edge, then settle at the falling edge for sampling/driving.
  task automatic tick();
    @(negedge SYS_CLK);
  endtask

  initial begin
    int rise, fall, npress, nrel, bad, rst_rise, rst_fall, lvl_rise, lvl_fall;
    int highs, prev_rst;

    RSTn   = 1'b0;
    bus.PB = 2'b11;
    repeat (3) tick();

    // Reset values
    check_val("rst_sys_rst", bus.sys_rst, 1);
    check_val("rst_free", bus.free_cnt, 0);
    check_val("rst_ce", bus.ce_div, 0);
    check_val("rst_level", bus.pb_level, 0);
    check_val("rst_press", bus.pb_press, 0);
    check_val("rst_release", bus.pb_release, 0);

    // POR hold: sys_rst high for 15 cycles, free_cnt counts and wraps, ce alternates
    RSTn = 1'b1;
    for (int n = 1; n <= 34; n++) begin
      tick();
      check_val("por_sys_rst", bus.sys_rst, (n < 15) ? 1 : 0);
      check_val("por_free", bus.free_cnt, (n > 15) ? ((n - 15) % 16) : 0);
      check_val("por_ce", bus.ce_div, n % 2);
    end

    // 3-cycle glitch on PB[1] must be ignored
    bad = 0;
    bus.PB[1] = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) bus.PB[1] = 1'b1;
      tick();
      if (bus.pb_level[1] || bus.pb_press[1] || bus.pb_release[1]) bad++;
    end
    check_val("glitch_ignored", bad, 0);

    // Clean press of PB[1]
    rise = -1; npress = 0; nrel = 0; bad = -1;
    bus.PB[1] = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.pb_press[1]) begin npress++; bad = i; end
      if (bus.pb_release[1]) nrel++;
      if (bus.pb_level[1] && rise < 0) rise = i;
    end
    check_val("press_latency_ok", (rise >= 5 && rise <= 7) ? 1 : 0, 1);
    check_val("press_pulses", npress, 1);
    check_val("press_pulse_at_rise", bad, rise);
    check_val("press_no_release", nrel, 0);
    check_val("press_level1", bus.pb_level[1], 1);
    check_val("press_level0", bus.pb_level[0], 0);
    check_val("press_sys_rst", bus.sys_rst, 0);

    // Release of PB[1]
    fall = -1; npress = 0; nrel = 0;
    bus.PB[1] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.pb_press[1]) npress++;
      if (bus.pb_release[1]) nrel++;
      if (!bus.pb_level[1] && fall < 0) fall = i;
    end
    check_val("release_latency_ok", (fall >= 5 && fall <= 7) ? 1 : 0, 1);
    check_val("release_pulses", nrel, 1);
    check_val("release_no_press", npress, 0);
    check_val("release_level1", bus.pb_level[1], 0);

    // Button reset via PB[0]: low for 20 cycles
    rst_rise = -1; rst_fall = -1; lvl_rise = -1; lvl_fall = -1;
    npress = 0; nrel = 0; bad = 0; highs = 0;
    prev_rst = bus.sys_rst;
    bus.PB[0] = 1'b0;
    for (int i = 1; i <= 70; i++) begin
      if (i == 21) bus.PB[0] = 1'b1;
      tick();
      if (bus.pb_press[0]) npress++;
      if (bus.pb_release[0]) nrel++;
      if (bus.pb_level[0] && lvl_rise < 0) lvl_rise = i;
      if (!bus.pb_level[0] && lvl_rise > 0 && lvl_fall < 0) lvl_fall = i;
      if (bus.sys_rst && rst_rise < 0) rst_rise = i;
      if (!bus.sys_rst && rst_rise > 0 && rst_fall < 0) rst_fall = i;
      if (bus.sys_rst) highs++;
      if (prev_rst != 0 && bus.free_cnt != 0) bad++;
      prev_rst = bus.sys_rst;
    end
    check_val("pbrst_rise_ok", (rst_rise >= 6 && rst_rise <= 8) ? 1 : 0, 1);
    check_val("pbrst_level_fall_ok", (lvl_fall >= 25 && lvl_fall <= 27) ? 1 : 0, 1);
    check_val("pbrst_hold_after_release", rst_fall - lvl_fall, 16);
    check_val("pbrst_continuous", highs, rst_fall - rst_rise);
    check_val("pbrst_free_zero", bad, 0);
    check_val("pbrst_press_pulses", npress, 1);
    check_val("pbrst_release_pulses", nrel, 1);

    // Async reset while a button is held: outputs clear immediately
    bus.PB[1] = 1'b0;
    repeat (10) tick();
    check_val("pre_rst_level1", bus.pb_level[1], 1);
    RSTn = 1'b0;
    #1;
    check_val("async_level", bus.pb_level, 0);
    check_val("async_sys_rst", bus.sys_rst, 1);
    check_val("async_free", bus.free_cnt, 0);
    bus.PB[1] = 1'b1;
    repeat (2) tick();

    // Abort a POR hold at hold count 8
    RSTn = 1'b1;
    repeat (9) tick();
    check_val("mid_hold_sys_rst", bus.sys_rst, 1);
    check_val("mid_hold_ce", bus.ce_div, 1);
    RSTn = 1'b0;
    #1;
    check_val("abort_sys_rst", bus.sys_rst, 1);
    check_val("abort_ce", bus.ce_div, 0);
    check_val("abort_free", bus.free_cnt, 0);
    check_val("abort_press", bus.pb_press, 0);
    check_val("abort_release", bus.pb_release, 0);
    tick();
    RSTn = 1'b1;
    rst_fall = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (!bus.sys_rst && rst_fall < 0) rst_fall = n;
    end
    check_val("abort_full_hold", rst_fall, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rst_ctrl_gen.md
RST_CTRL_GEN -- requirements
Module: rst_ctrl_gen

Interface
REQ-001 Parameter NUM_PB, default 4: number of active-low pushbutton inputs, legal range 1..8.
REQ-002 Parameter POR_CYCLES, default 14: power-on reset hold length in SYS_CLK cycles, minimum 1.
REQ-003 Parameter DEB_CYCLES, default 500000: consecutive stable cycles to accept a button change, minimum 2.
REQ-004 Parameter DIV, default 2: clock-enable period in SYS_CLK cycles, minimum 2.
REQ-005 Parameter CNT_WIDTH, default 26: free-running counter width.
REQ-006 Parameter RST_PB, default 0: index of the button that forces system reset.
REQ-007 SYS_CLK  in  1  sole clock (50 MHz); all logic on its rising edge.
REQ-008 RSTn  in  1  asynchronous, active-low reset.
REQ-009 PB  in  NUM_PB  raw pushbuttons, asynchronous, low = pressed.
REQ-010 sys_rst  out  1  active-high system reset for downstream logic.
REQ-011 pb_level  out  NUM_PB  debounced state, 1 = pressed.
REQ-012 pb_press  out  NUM_PB  one-cycle pulse on debounced press.
REQ-013 pb_release  out  NUM_PB  one-cycle pulse on debounced release.
REQ-014 ce_div  out  1  one-cycle clock enable, once every DIV cycles.
REQ-015 free_cnt  out  CNT_WIDTH  free-running count, cleared while sys_rst is high.

Function
REQ-016 Each PB bit shall pass through a 2-flop synchroniser before any other use.
REQ-017 Per channel, a counter shall count cycles in which the synchronised input differs from pb_level; any cycle of agreement shall clear it.
REQ-018 When the counter reaches DEB_CYCLES-1 while still differing, pb_level shall toggle on the next edge and the counter shall clear.
REQ-019 pb_press shall be high for exactly the cycle in which pb_level goes 0->1, and pb_release exactly when it goes 1->0; both shall never be high together on one channel.
REQ-020 Total press latency from a PB falling edge to pb_level rising shall be 2 + DEB_CYCLES cycles, with ±1 cycle allowed for synchroniser sampling.
REQ-021 The reset FSM shall have exactly three states: S_POR, S_RUN and S_PBRST.
REQ-022 In S_POR, a hold counter shall increment each cycle; the FSM shall go to S_RUN when the counter equals POR_CYCLES-1.
REQ-023 In S_RUN, the FSM shall go to S_PBRST when pb_level[RST_PB] is 1.
REQ-024 In S_PBRST, the FSM shall go to S_POR with the hold counter cleared when pb_level[RST_PB] is 0, so every button reset is followed by a full POR hold.
REQ-025 sys_rst shall be a registered output, high in S_POR and S_PBRST and low only in S_RUN.
REQ-026 ce_div shall come from a modulo-DIV counter pulsing at count DIV-1; it shall run independently of sys_rst, and no derived clock shall be generated.
REQ-027 free_cnt shall increment each cycle while sys_rst is low, wrap from all-ones to 0, and hold at 0 while sys_rst is high.
REQ-028 A press and release of RST_PB shall still produce pb_press and pb_release pulses.

Reset
REQ-029 On RSTn low, the block shall asynchronously clear all outputs, with these exceptions: sys_rst = 1, the FSM = S_POR, and the hold counter = 0.
REQ-030 On RSTn low, synchroniser flops shall be set to 1 (released), and the debounce counters, ce_div counter and free_cnt shall be cleared.
REQ-031 RSTn asserted mid-debounce or mid-hold shall abort the operation; after release, the full POR_CYCLES hold shall restart.

Structure
REQ-032 The FSM state encoding and the default parameter constants shall live in a shared package, rst_ctrl_pkg.
REQ-033 One sub-module, pb_debounce (a single channel: synchroniser, counter, level and edge pulses), shall be instanced NUM_PB times in a generate loop.

Verification
REQ-034 The bench shall use NUM_PB=2, POR_CYCLES=15, DEB_CYCLES=4, DIV=2, CNT_WIDTH=4 for REQ-035 to REQ-039.
REQ-035 Release RSTn with PB=2'b11 -> sys_rst high for exactly 15 cycles then low; free_cnt counts 0..15 then wraps to 0; ce_div pulses every second cycle throughout.
REQ-036 Drive PB[1] low for 3 cycles, then high -> no change on pb_level[1] and no pulses.
REQ-037 Drive PB[1] low and hold -> pb_level[1] rises 6 cycles later (±1) with one single-cycle pb_press[1]; driving PB[1] high again gives one pb_release[1].
REQ-038 In S_RUN, hold PB[0] low for 20 cycles, then release -> sys_rst rises ~6 cycles after the press, stays high through release debounce plus 15 more cycles, and free_cnt stays at 0 throughout.
REQ-039 Assert RSTn at cycle 8 of the POR hold -> all outputs at reset values immediately; after release, sys_rst stays high for a full 15 cycles.
